bcd_display_scanner: RTL and testbench

Multiplexed 4-digit seven-segment driver that consumes the stopwatch's 16-bit BCD MM:SS value, where D[3:0] is the seconds ones digit and D[15:12] is the minutes tens digit. It snapshots the value once per frame, so a frame never shows a half-updated count. It scans the digits with an anti-ghosting guard interval, blanks a leading minutes-tens zero, shows a dash for any non-BCD nibble, and blinks the MM:SS colon. It sits between the stopwatch counter outputs and the board's display pins.

---
 rtl/bcd_display_scanner_if.sv | 14 +
 rtl/bcd_display_scanner.sv | 110 +++++++++++
 tb/tb_bcd_display_scanner.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bcd_display_scanner_if.sv
// Display-side bundle for the BCD scanner: the MM:SS value and display options go in,
// and the registered segment, colon, anode and frame-strobe outputs come back.
interface bcd_display_scanner_if;
    logic [15:0] D;
    logic        BLANK_LZ;
    logic        BLINK_EN;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  AN;
    logic        FRAME_DONE;

    modport master (output D, BLANK_LZ, BLINK_EN, input SEG, DP, AN, FRAME_DONE);
    modport slave  (input D, BLANK_LZ, BLINK_EN, output SEG, DP, AN, FRAME_DONE);
endinterface

// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed seven-segment scanner. It captures the BCD value once per frame,
// applies an all-off guard at the start of each digit slot, and blinks the MM:SS colon.
module bcd_display_scanner #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned GUARD     = 4,
    parameter int unsigned BLINK_DIV = 125
) (
    input  logic                  clk,
    input  logic                  RESET_N,
    bcd_display_scanner_if.slave  bus
);
    localparam int unsigned PC_W = $clog2(SCAN_DIV);
    localparam int unsigned FC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    logic [PC_W-1:0] r_pc;
    logic [1:0]      r_idx;
    logic [15:0]     r_snap;
    logic [FC_W-1:0] r_fc;
    logic            r_phase;
    logic [6:0]      r_seg_p1;
    logic            r_dp_p1;
    logic [3:0]      r_an_p1;
    logic            r_frame_done_p1;

    logic            w_tick;
    logic            w_frame;
    logic [3:0]      w_nib;
    logic [6:0]      w_seg;
    logic            w_dp;
    logic [3:0]      w_an;

    assign w_tick  = (r_pc == PC_W'(SCAN_DIV - 1));
    assign w_frame = w_tick && (r_idx == 2'd3);
    assign w_nib   = r_snap[{r_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pc    <= '0;
            r_idx   <= '0;
            r_snap  <= '0;
            r_fc    <= '0;
            r_phase <= 1'b0;
        end else begin
            r_pc <= w_tick ? '0 : r_pc + 1'b1;
            if (w_tick)
                r_idx <= r_idx + 2'd1;
            // The snapshot only moves at the frame boundary so a frame never mixes two counts.
            if (w_frame) begin
                r_snap <= bus.D;
                if (r_fc == FC_W'(BLINK_DIV - 1)) begin
                    r_fc    <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fc <= r_fc + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_seg = 7'b1111111;
        w_an  = 4'b1111;
        w_dp  = 1'b1;
        if (r_pc >= PC_W'(GUARD)) begin
            w_an = ~(4'b0001 << r_idx);
            if (!((r_idx == 2'd3) && bus.BLANK_LZ && (w_nib == 4'd0)))
                w_seg = seg_decode(w_nib);
            if ((r_idx == 2'd2) && (!bus.BLINK_EN || r_phase))
                w_dp = 1'b0;
        end
    end

    // Stage p1: registered pin drivers, one cycle behind the scan state.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_seg_p1        <= 7'b1111111;
            r_dp_p1         <= 1'b1;
            r_an_p1         <= 4'b1111;
            r_frame_done_p1 <= 1'b0;
        end else begin
            r_seg_p1        <= w_seg;
            r_dp_p1         <= w_dp;
            r_an_p1         <= w_an;
            r_frame_done_p1 <= w_frame;
        end
    end

    assign bus.SEG        = r_seg_p1;
    assign bus.DP         = r_dp_p1;
    assign bus.AN         = r_an_p1;
    assign bus.FRAME_DONE = r_frame_done_p1;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with SCAN_DIV=8, GUARD=2, BLINK_DIV=2.
module tb_bcd_display_scanner;
    localparam int P_SCAN  = 8;
    localparam int P_GUARD = 2;
    localparam int P_BLINK = 2;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SDASH = 7'b0111111, SBLK = 7'b1111111;
    localparam logic [27:0] ZEROS = {S0, S0, S0, S0};

    logic clk = 1'b0;
    logic RESET_N;

    bcd_display_scanner_if bus ();

    bcd_display_scanner #(
        .SCAN_DIV (P_SCAN),
        .GUARD    (P_GUARD),
        .BLINK_DIV(P_BLINK)
    ) dut (
        .clk    (clk),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        logic        lz;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
        string       name;
    } vec_t;

    vec_t vecs[6];

    // Compares {AN, SEG, DP, FRAME_DONE}.
    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got AN=%b SEG=%b DP=%b FD=%b, want AN=%b SEG=%b DP=%b FD=%b",
                     name, act[12:9], act[8:2], act[1], act[0], exp[12:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    // k counts clock edges from the start of a frame; the edge k=32 ends it with a capture.
    task automatic check_edges(input string tag, input logic [27:0] segs, input bit dp_lit,
                               input int from, input int to);
        for (int k = from; k <= to; k++) begin
            int pc;
            int idx;
            logic [3:0] an;
            logic [6:0] sg;
            logic       dp;
            logic       fd;
            @(posedge clk); #1;
            pc  = (k - 1) % P_SCAN;
            idx = (k - 1) / P_SCAN;
            if (pc < P_GUARD) begin
                an = 4'b1111;
                sg = SBLK;
                dp = 1'b1;
            end else begin
                an = ~(4'b0001 << idx);
                sg = segs[idx*7 +: 7];
                dp = !(idx == 2 && dp_lit);
            end
            fd = (k == 4 * P_SCAN);
            chk($sformatf("%s k%0d", tag, k), {bus.AN, bus.SEG, bus.DP, bus.FRAME_DONE},
                {an, sg, dp, fd});
        end
    endtask

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.FRAME_DONE && n < 40);
        checks++;
        if (!bus.FRAME_DONE) begin
            errors++;
            $display("FAIL %s frame_done timeout: got FD=0 after %0d cycles, want FD=1", tag, n);
        end
    endtask

    initial begin
        vecs[0] = '{16'h1259, 1'b0, {S1, S2, S5, S9},       "v1259"};
        vecs[1] = '{16'h0A07, 1'b1, {SBLK, SDASH, S0, S7},  "v0A07lz"};
        vecs[2] = '{16'h0A07, 1'b0, {S0, SDASH, S0, S7},    "v0A07"};
        vecs[3] = '{16'h4321, 1'b1, {S4, S3, S2, S1},       "v4321"};
        vecs[4] = '{16'hF086, 1'b1, {SDASH, S0, S8, S6},    "vF086"};
        vecs[5] = '{16'h0000, 1'b1, {SBLK, S0, S0, S0},     "v0000lz"};

        // Reset state, then release and the first six frames with the colon blinking.
        RESET_N      = 1'b0;
        bus.D        = 16'h0000;
        bus.BLANK_LZ = 1'b0;
        bus.BLINK_EN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", {bus.AN, bus.SEG, bus.DP, bus.FRAME_DONE}, {4'b1111, SBLK, 1'b1, 1'b0});
        @(negedge clk);
        RESET_N = 1'b1;
        for (int f = 0; f < 6; f++)
            check_edges($sformatf("blink f%0d", f), ZEROS, (f == 2 || f == 3), 1, 32);

        // Tear-free capture: D changes during digit 1, the frame keeps showing zeros.
        bus.BLINK_EN = 1'b0;
        check_edges("tear pre", ZEROS, 1'b1, 1, 10);
        bus.D = 16'h4321;
        check_edges("tear rest", ZEROS, 1'b1, 11, 32);
        check_edges("tear next", {S4, S3, S2, S1}, 1'b1, 1, 32);

        // Table of snapshot/decode/blanking vectors.
        for (int v = 0; v < 6; v++) begin
            bus.D        = vecs[v].d;
            bus.BLANK_LZ = vecs[v].lz;
            wait_fd(vecs[v].name);
            check_edges(vecs[v].name, vecs[v].segs, 1'b1, 1, 32);
        end

        // Asynchronous reset during digit 2 with 1234 on display.
        bus.BLANK_LZ = 1'b0;
        bus.D        = 16'h1234;
        wait_fd("r1234");
        check_edges("r1234", {S1, S2, S3, S4}, 1'b1, 1, 20);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_reset_now", {bus.AN, bus.SEG, bus.DP, bus.FRAME_DONE}, {4'b1111, SBLK, 1'b1, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        chk("async_reset_held", {bus.AN, bus.SEG, bus.DP, bus.FRAME_DONE}, {4'b1111, SBLK, 1'b1, 1'b0});
        @(negedge clk);
        RESET_N = 1'b1;
        check_edges("post_reset", ZEROS, 1'b1, 1, 32);
        check_edges("post_capture", {S1, S2, S3, S4}, 1'b1, 1, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
